// File: rtl/types_pkg.sv
// Shared types for the data-memory responder: FSM state, latched request and sizing constants.
package types_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    DMEM_IDLE,
    DMEM_WAIT,
    DMEM_RESP
  } dmem_state_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } dmem_req_t;
endpackage

// File: rtl/wait_counter.sv
// Wait-state down-counter: loads on request acceptance, decrements while waiting, flags the last wait cycle.
module wait_counter
  import types_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // A count of one means this is the final wait cycle.
  assign o_done = (r_cnt <= CNT_W'(1));

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request intake, WAIT_STATES wait cycles, one-cycle response.
// Optional out-of-range detection is enabled by defining DMEM_BOUNDS_CHECK_EN.
module dmem_responder
  import types_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt_sys,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              stall,
  output logic              rsp_err
);

  localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [16:0] LP_DEPTH  = 17'(DEPTH);
`ifdef DMEM_BOUNDS_CHECK_EN
  localparam logic        LP_CHECK  = 1'b1;
`else
  localparam logic        LP_CHECK  = 1'b0;
`endif

  function automatic logic f_oob(input logic [ADDR_W-1:0] a);
    return LP_CHECK && ({1'b0, a} >= LP_DEPTH);
  endfunction

  dmem_state_t       r_state;
  dmem_req_t         r_req;
  logic              r_ready;
  logic              r_rsp_valid;
  logic              r_stall;
  logic              r_err;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_accept;
  logic              w_done;
  logic              w_commit;
  logic [AW-1:0]     w_idx;

  assign req_ready = r_ready & ~halt_sys;
  assign w_accept  = req_valid & req_ready;
  // Upper address bits fall away here, so accesses wrap modulo DEPTH.
  assign w_idx     = AW'(r_req.addr);
  assign w_commit  = (r_state == DMEM_RESP) & ~halt_sys & r_req.write & ~r_err;

  wait_counter u_wait_counter (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_accept),
    .i_load_val (CNT_W'(WAIT_STATES)),
    .i_dec      ((r_state == DMEM_WAIT) & ~halt_sys),
    .o_done     (w_done)
  );

  // Request latch: data only, captured at acceptance.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_req <= '{write: req_write, addr: req_addr, wdata: req_wdata};
    end
  end

  // Control FSM; halt_sys freezes every transition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= DMEM_IDLE;
      r_ready     <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_stall     <= 1'b0;
      r_err       <= 1'b0;
    end else if (!halt_sys) begin
      case (r_state)
        DMEM_IDLE: begin
          if (w_accept) begin
            r_ready <= 1'b0;
            r_stall <= 1'b1;
            if (WAIT_STATES == 0) begin
              r_state     <= DMEM_RESP;
              r_rsp_valid <= 1'b1;
              r_err       <= f_oob(req_addr);
            end else begin
              r_state <= DMEM_WAIT;
            end
          end
        end
        DMEM_WAIT: begin
          if (w_done) begin
            r_state     <= DMEM_RESP;
            r_rsp_valid <= 1'b1;
            r_err       <= f_oob(r_req.addr);
          end
        end
        DMEM_RESP: begin
          r_state     <= DMEM_IDLE;
          r_ready     <= 1'b1;
          r_rsp_valid <= 1'b0;
          r_stall     <= 1'b0;
          r_err       <= 1'b0;
        end
        default: begin
          r_state     <= DMEM_IDLE;
          r_ready     <= 1'b1;
          r_rsp_valid <= 1'b0;
          r_stall     <= 1'b0;
          r_err       <= 1'b0;
        end
      endcase
    end
  end

  // Store commit on the edge that leaves RESP.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_mem[w_idx] <= r_req.wdata;
    end
  end

  assign rsp_rdata = (r_rsp_valid && !r_req.write && !r_err) ? r_mem[w_idx] : '0;
  assign rsp_valid = r_rsp_valid;
  assign stall     = r_stall;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states, one with none.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        halt = 1'b0, vld = 1'b0, wr = 1'b0;
  logic [15:0] addr = '0, wdata = '0;
  logic        rdy, rv, stl, err;
  logic [15:0] rdata;

  logic        d0_halt = 1'b0, d0_vld = 1'b0, d0_wr = 1'b0;
  logic [15:0] d0_addr = '0, d0_wdata = '0;
  logic        d0_rdy, d0_rv, d0_stl, d0_err;
  logic [15:0] d0_rdata;

  int nv = 0;
  int ne = 0;

  dmem_responder #(.DEPTH(256), .WAIT_STATES(2)) u_dut (
    .clk(clk), .rst(rst), .halt_sys(halt), .req_valid(vld), .req_write(wr),
    .req_addr(addr), .req_wdata(wdata), .req_ready(rdy), .rsp_valid(rv),
    .rsp_rdata(rdata), .stall(stl), .rsp_err(err)
  );

  dmem_responder #(.DEPTH(256), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst), .halt_sys(d0_halt), .req_valid(d0_vld), .req_write(d0_wr),
    .req_addr(d0_addr), .req_wdata(d0_wdata), .req_ready(d0_rdy), .rsp_valid(d0_rv),
    .rsp_rdata(d0_rdata), .stall(d0_stl), .rsp_err(d0_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request on u_dut from IDLE; returns response data, error, latency and stall cycles.
  task automatic xact(input logic w, input logic [15:0] a, input logic [15:0] d,
                      output logic [15:0] rd, output logic e, output int lat, output int sc);
    vld = 1'b1; wr = w; addr = a; wdata = d;
    tick();
    vld = 1'b0;
    lat = -1; sc = 0; rd = 16'h0; e = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (stl) sc++;
      if (rv) begin
        lat = c; rd = rdata; e = err;
        tick();
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    nv++; if (rdy !== 1'b1) begin ne++; $display("FAIL reset_ready: got %b want 1", rdy); end
    nv++; if (rv !== 1'b0) begin ne++; $display("FAIL reset_rsp_valid: got %b want 0", rv); end
    nv++; if (rdata !== 16'h0) begin ne++; $display("FAIL reset_rdata: got %h want 0000", rdata); end
    nv++; if (stl !== 1'b0) begin ne++; $display("FAIL reset_stall: got %b want 0", stl); end
    nv++; if (err !== 1'b0) begin ne++; $display("FAIL reset_err: got %b want 0", err); end
    nv++; if (d0_rdy !== 1'b1) begin ne++; $display("FAIL reset_ready_ws0: got %b want 1", d0_rdy); end
    tick(); tick();
    rst = 1'b1;
    tick();
    nv++; if (rdy !== 1'b1 || stl !== 1'b0) begin ne++; $display("FAIL post_reset_idle: got rdy=%b stall=%b want 1/0", rdy, stl); end
  endtask

  task automatic test_store_load();
    logic [15:0] rd; logic e; int lat, sc;
    xact(1'b1, 16'h0010, 16'hBEEF, rd, e, lat, sc);
    nv++; if (lat !== 3) begin ne++; $display("FAIL store_latency: got %0d want 3", lat); end
    nv++; if (sc !== 3) begin ne++; $display("FAIL store_stall_cycles: got %0d want 3", sc); end
    nv++; if (e !== 1'b0) begin ne++; $display("FAIL store_err: got %b want 0", e); end
    xact(1'b0, 16'h0010, 16'h0000, rd, e, lat, sc);
    nv++; if (lat !== 3) begin ne++; $display("FAIL load_latency: got %0d want 3", lat); end
    nv++; if (sc !== 3) begin ne++; $display("FAIL load_stall_cycles: got %0d want 3", sc); end
    nv++; if (rd !== 16'hBEEF) begin ne++; $display("FAIL load_rdata: got %h want BEEF", rd); end
    nv++; if (rdy !== 1'b1 || stl !== 1'b0) begin ne++; $display("FAIL store_load_idle: got rdy=%b stall=%b want 1/0", rdy, stl); end
  endtask

  task automatic test_back_to_back();
    logic        exp_rv;
    logic [15:0] exp_rd;
    int          pulses = 0;
    d0_vld = 1'b1; d0_wr = 1'b1; d0_addr = 16'h0001; d0_wdata = 16'hAAAA;
    tick();
    nv++; if (d0_rv !== 1'b1) begin ne++; $display("FAIL b2b_store1_rv: got %b want 1", d0_rv); end
    d0_addr = 16'h0002; d0_wdata = 16'hBBBB;
    tick();
    nv++; if (d0_rv !== 1'b0 || d0_rdy !== 1'b1) begin ne++; $display("FAIL b2b_store_gap: got rv=%b rdy=%b want 0/1", d0_rv, d0_rdy); end
    tick();
    nv++; if (d0_rv !== 1'b1) begin ne++; $display("FAIL b2b_store2_rv: got %b want 1", d0_rv); end
    d0_vld = 1'b0;
    tick();
    d0_vld = 1'b1; d0_wr = 1'b0; d0_addr = 16'h0001;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_rv = ((i % 2) == 0);
      exp_rd = ((i % 4) == 0) ? 16'hAAAA : 16'hBBBB;
      nv++; if (d0_rv !== exp_rv || d0_stl !== exp_rv) begin ne++; $display("FAIL b2b_pulse[%0d]: got rv=%b stall=%b want %b", i, d0_rv, d0_stl, exp_rv); end
      if (d0_rv) begin
        pulses++;
        nv++; if (d0_rdata !== exp_rd) begin ne++; $display("FAIL b2b_rdata[%0d]: got %h want %h", i, d0_rdata, exp_rd); end
        d0_addr = (d0_addr == 16'h0001) ? 16'h0002 : 16'h0001;
      end
    end
    d0_vld = 1'b0;
    nv++; if (pulses !== 4) begin ne++; $display("FAIL b2b_pulse_count: got %0d want 4", pulses); end
    tick();
  endtask

  task automatic test_wrap();
    logic [15:0] rd; logic e; int lat, sc;
    logic        exp_st_err, exp_hi_err;
    logic [15:0] exp_lo, exp_hi;
`ifdef DMEM_BOUNDS_CHECK_EN
    exp_st_err = 1'b1; exp_hi_err = 1'b1; exp_lo = 16'h5555; exp_hi = 16'h0000;
`else
    exp_st_err = 1'b0; exp_hi_err = 1'b0; exp_lo = 16'h1234; exp_hi = 16'h1234;
`endif
    xact(1'b1, 16'h0005, 16'h5555, rd, e, lat, sc);
    xact(1'b1, 16'h0105, 16'h1234, rd, e, lat, sc);
    nv++; if (e !== exp_st_err || lat !== 3) begin ne++; $display("FAIL wrap_store_err: got err=%b lat=%0d want %b/3", e, lat, exp_st_err); end
    xact(1'b0, 16'h0005, 16'h0000, rd, e, lat, sc);
    nv++; if (rd !== exp_lo || e !== 1'b0) begin ne++; $display("FAIL wrap_load_low: got %h err=%b want %h/0", rd, e, exp_lo); end
    xact(1'b0, 16'h0105, 16'h0000, rd, e, lat, sc);
    nv++; if (rd !== exp_hi || e !== exp_hi_err) begin ne++; $display("FAIL wrap_load_high: got %h err=%b want %h/%b", rd, e, exp_hi, exp_hi_err); end
  endtask

  task automatic test_halt();
    logic [15:0] rd; logic e; int lat, sc;
    int rv_cyc = 0;
    halt = 1'b1; vld = 1'b1; wr = 1'b0; addr = 16'h0010;
    #1;
    nv++; if (rdy !== 1'b0) begin ne++; $display("FAIL halt_idle_ready: got %b want 0", rdy); end
    tick();
    nv++; if (stl !== 1'b0) begin ne++; $display("FAIL halt_idle_accept: got stall=%b want 0", stl); end
    halt = 1'b0; vld = 1'b0;
    xact(1'b1, 16'h0030, 16'h1111, rd, e, lat, sc);
    vld = 1'b1; wr = 1'b1; addr = 16'h0030; wdata = 16'hA5A5;
    tick();
    vld = 1'b0;
    tick(); tick();
    if (rv) rv_cyc++;
    halt = 1'b1;
    #1;
    nv++; if (rdy !== 1'b0) begin ne++; $display("FAIL halt_resp_ready: got %b want 0", rdy); end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rv) rv_cyc++;
    end
    halt = 1'b0;
    tick();
    nv++; if (rv_cyc !== 5) begin ne++; $display("FAIL halt_rv_cycles: got %0d want 5", rv_cyc); end
    nv++; if (rv !== 1'b0 || rdy !== 1'b1) begin ne++; $display("FAIL halt_release: got rv=%b rdy=%b want 0/1", rv, rdy); end
    xact(1'b0, 16'h0030, 16'h0000, rd, e, lat, sc);
    nv++; if (rd !== 16'hA5A5) begin ne++; $display("FAIL halt_commit: got %h want A5A5", rd); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] rd; logic e; int lat, sc;
    xact(1'b1, 16'h0020, 16'h0000, rd, e, lat, sc);
    vld = 1'b1; wr = 1'b1; addr = 16'h0020; wdata = 16'hFFFF;
    tick();
    vld = 1'b0;
    nv++; if (stl !== 1'b1) begin ne++; $display("FAIL midrst_in_wait: got stall=%b want 1", stl); end
    rst = 1'b0;
    #1;
    nv++; if (stl !== 1'b0 || rdy !== 1'b1 || rv !== 1'b0 || err !== 1'b0) begin
      ne++; $display("FAIL midrst_outputs: got stall=%b rdy=%b rv=%b err=%b want 0/1/0/0", stl, rdy, rv, err);
    end
    tick(); tick();
    rst = 1'b1;
    tick();
    xact(1'b0, 16'h0020, 16'h0000, rd, e, lat, sc);
    nv++; if (rd !== 16'h0000 || lat !== 3) begin ne++; $display("FAIL midrst_lost_store: got %h lat=%0d want 0000/3", rd, lat); end
  endtask

  task automatic test_valid_in_resp();
    vld = 1'b1; wr = 1'b1; addr = 16'h0040; wdata = 16'h7777;
    tick();
    vld = 1'b0;
    tick(); tick();
    nv++; if (rv !== 1'b1) begin ne++; $display("FAIL vir_in_resp: got rv=%b want 1", rv); end
    vld = 1'b1; wr = 1'b0; addr = 16'h0040;
    #1;
    nv++; if (rdy !== 1'b0) begin ne++; $display("FAIL vir_ready_in_resp: got %b want 0", rdy); end
    tick();
    nv++; if (stl !== 1'b0 || rdy !== 1'b1) begin ne++; $display("FAIL vir_not_accepted: got stall=%b rdy=%b want 0/1", stl, rdy); end
    tick();
    vld = 1'b0;
    nv++; if (stl !== 1'b1) begin ne++; $display("FAIL vir_accepted: got stall=%b want 1", stl); end
    tick(); tick();
    nv++; if (rv !== 1'b1 || rdata !== 16'h7777) begin ne++; $display("FAIL vir_load: got rv=%b rdata=%h want 1/7777", rv, rdata); end
    tick(); tick(); tick();
    nv++; if (stl !== 1'b0 || rv !== 1'b0) begin ne++; $display("FAIL vir_no_duplicate: got stall=%b rv=%b want 0/0", stl, rv); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_back_to_back();
    test_wrap();
    test_halt();
    test_reset_mid();
    test_valid_in_resp();
    $display("== %0d vectors applied, %0d miscompares ==", nv, ne);
    $finish;
  end

endmodule
